// File: rtl/cmp_serial_loader_if.sv
// Bundle of the serial input link and the registered operand output of cmp_serial_loader.
// The loader uses the slave modport; whatever feeds bits and consumes operands uses master.
interface cmp_serial_loader_if #(
  parameter int W = 4
) ();
  logic         sin_valid;
  logic         sin_start;
  logic         sin_data;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         op_valid;
  logic         op_ready;
  logic         busy;
  logic         frame_err;

  modport master (
    output sin_valid, sin_start, sin_data, op_ready,
    input  a_out, b_out, op_valid, busy, frame_err
  );

  modport slave (
    input  sin_valid, sin_start, sin_data, op_ready,
    output a_out, b_out, op_valid, busy, frame_err
  );
endinterface

// File: rtl/cmp_serial_loader.sv
// Deserialises A/B operand frames (LSB first) into a held valid/ready pair for the comparator.
// Define CMP_LOADER_PARITY_EN to append an even-parity bit to every frame.
module cmp_serial_loader #(
  parameter int W = 4
) (
  input logic              clk,
  input logic              rst_n,
  cmp_serial_loader_if.slave bus
);

`ifdef CMP_LOADER_PARITY_EN
  localparam int NBITS = 2*W + 1;
`else
  localparam int NBITS = 2*W;
`endif
  localparam int CW = $clog2(2*W + 2);

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic [2*W-1:0]  r_shift;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_op_valid;
  logic            r_frame_err;

  logic            w_shift_en;
  logic            w_data_en;
  logic            w_restart;
  logic            w_last;
  logic            w_free;
  logic            w_par_ok;
  logic            w_load;
  logic            w_err;
  logic [2*W-1:0]  w_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // A start bit always begins a fresh frame, even mid-frame, so the count restarts at 1.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_shift_en   = 1'b0;
    w_restart    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sin_valid && bus.sin_start) begin
          w_next_state = S_SHIFT;
          w_next_cnt   = CW'(1);
          w_shift_en   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.sin_valid) begin
          w_shift_en = 1'b1;
          if (bus.sin_start) begin
            w_restart  = 1'b1;
            w_next_cnt = CW'(1);
          end else if (r_cnt == CW'(NBITS - 1)) begin
            w_last       = 1'b1;
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

`ifdef CMP_LOADER_PARITY_EN
  logic r_par;

  // Running XOR of the data bits; reseeded by every start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_shift_en) begin
      r_par <= bus.sin_start ? bus.sin_data : (r_par ^ bus.sin_data);
    end
  end

  assign w_par_ok  = ~(r_par ^ bus.sin_data);
  assign w_data_en = w_shift_en & ~w_last;
  assign w_frame   = r_shift;
`else
  assign w_par_ok  = 1'b1;
  assign w_data_en = w_shift_en;
  assign w_frame   = {bus.sin_data, r_shift[2*W-1:1]};
`endif

  assign w_free = ~r_op_valid | bus.op_ready;
  assign w_load = w_last & w_free & w_par_ok;
  assign w_err  = w_restart | (w_last & ~(w_free & w_par_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_data_en) begin
      r_shift <= {bus.sin_data, r_shift[2*W-1:1]};
    end
  end

  // A load wins over consumption, giving a bubble-free handoff when both coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_load) begin
        r_a        <= w_frame[W-1:0];
        r_b        <= w_frame[2*W-1:W];
        r_op_valid <= 1'b1;
      end else if (r_op_valid && bus.op_ready) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.op_valid  = r_op_valid;
  assign bus.busy      = (r_state == S_SHIFT);
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_cmp_serial_loader.sv
// Self-checking bench for cmp_serial_loader: directed scenarios plus random frames against a frame-level model.
// Honours CMP_LOADER_PARITY_EN the same way the design does.
module tb_cmp_serial_loader;
  localparam int W = 4;
`ifdef CMP_LOADER_PARITY_EN
  localparam int FLEN = 2*W + 1;
`else
  localparam int FLEN = 2*W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   errPulses = 0;

  logic [W-1:0] expA = '0;
  logic [W-1:0] expB = '0;
  logic         expValid = 1'b0;
  int           expErr = 0;
  logic         expPulse;
  logic [W-1:0] ra, rb;
  logic         bad;
  int           mode;

  cmp_serial_loader_if #(.W(W)) bus ();

  cmp_serial_loader #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // frame_err is sampled at the edge after it rises, so a pulse is counted one cycle late.
  always @(posedge clk) begin
    if (bus.frame_err === 1'b1) errPulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic v, input logic s, input logic d);
    @(negedge clk);
    bus.sin_valid = v;
    bus.sin_start = s;
    bus.sin_data  = d;
  endtask

  task automatic idleCycle();
    driveBit(1'b0, 1'b0, 1'b0);
  endtask

  // Frame bits come straight from the frame format: A LSB first, B LSB first, then optional even parity.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int gapPct,
                               input logic badPar, input logic raiseReady);
    logic [2*W:0] bits;
    for (int i = 0; i < W; i++) begin
      bits[i]     = a[i];
      bits[W + i] = b[i];
    end
    bits[2*W] = (^{a, b}) ^ badPar;
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3 && $urandom_range(99) < gapPct; g++)
          driveBit(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      driveBit(1'b1, (i == 0), bits[i]);
      if (raiseReady && i == FLEN - 1) bus.op_ready = 1'b1;
    end
  endtask

  task automatic sendPartial(input int k);
    for (int i = 0; i < k; i++) driveBit(1'b1, (i == 0), 1'($urandom_range(1)));
  endtask

  // Frame-level reference: a good frame loads if the slot is free, anything else is one error.
  task automatic modelFrame(input logic [W-1:0] a, input logic [W-1:0] b, input logic parOk,
                            input logic readyNow, output logic pulse);
    pulse = 1'b0;
    if (parOk && (!expValid || readyNow)) begin
      expA = a;
      expB = b;
      expValid = 1'b1;
    end else begin
      expErr++;
      pulse = 1'b1;
    end
  endtask

  task automatic checkPair(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.op_valid), 32'(expValid));
    checkOutput({tag, "_a"}, 32'(bus.a_out), 32'(expA));
    checkOutput({tag, "_b"}, 32'(bus.b_out), 32'(expB));
  endtask

  // After a completed frame: check the pair, then let any consumption happen and check error totals.
  task automatic finishFrame(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic parOk);
    logic pulse;
    idleCycle();
    modelFrame(a, b, parOk, bus.op_ready, pulse);
    checkPair(tag);
    checkOutput({tag, "_err"}, 32'(bus.frame_err), 32'(pulse));
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    idleCycle();
    if (bus.op_ready) expValid = 1'b0;
    idleCycle();
    checkOutput({tag, "_valid2"}, 32'(bus.op_valid), 32'(expValid));
    checkOutput({tag, "_errcnt"}, 32'(errPulses), 32'(expErr));
  endtask

  initial begin
    bus.sin_valid = 1'b0;
    bus.sin_start = 1'b0;
    bus.sin_data  = 1'b0;
    bus.op_ready  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkPair("reset");
    checkOutput("reset_err", 32'(bus.frame_err), 32'd0);

    for (int i = 0; i < 5; i++) driveBit(1'b1, 1'b0, 1'($urandom_range(1)));
    idleCycle();
    checkOutput("idle_noise_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_noise_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("idle_noise_err", 32'(errPulses), 32'd0);

    $display("[TB] basic load");
    bus.op_ready = 1'b1;
    applyStimulus(4'h9, 4'h3, 0, 1'b0, 1'b0);
    checkOutput("basic_busy", 32'(bus.busy), 32'd1);
    finishFrame("basic", 4'h9, 4'h3, 1'b1);

    $display("[TB] backpressure and overrun");
    bus.op_ready = 1'b0;
    applyStimulus(4'h9, 4'h3, 0, 1'b0, 1'b0);
    finishFrame("hold", 4'h9, 4'h3, 1'b1);
    applyStimulus(4'h5, 4'hA, 0, 1'b0, 1'b0);
    finishFrame("overrun", 4'h5, 4'hA, 1'b1);

    $display("[TB] zero-bubble handoff");
    applyStimulus(4'hF, 4'h0, 0, 1'b0, 1'b1);
    idleCycle();
    modelFrame(4'hF, 4'h0, 1'b1, 1'b1, expPulse);
    checkPair("handoff");
    checkOutput("handoff_err", 32'(bus.frame_err), 32'(expPulse));
    bus.op_ready = 1'b0;
    idleCycle();
    idleCycle();
    checkPair("handoff_hold");
    checkOutput("handoff_errcnt", 32'(errPulses), 32'(expErr));

    $display("[TB] restart");
    bus.op_ready = 1'b1;
    sendPartial(3);
    expErr++;
    applyStimulus(4'h2, 4'h7, 0, 1'b0, 1'b0);
    finishFrame("restart", 4'h2, 4'h7, 1'b1);

    $display("[TB] gaps");
    applyStimulus(4'hC, 4'h5, 60, 1'b0, 1'b0);
    finishFrame("gaps", 4'hC, 4'h5, 1'b1);

    $display("[TB] reset mid-frame");
    bus.op_ready = 1'b0;
    applyStimulus(4'h6, 4'hC, 0, 1'b0, 1'b0);
    finishFrame("prereset", 4'h6, 4'hC, 1'b1);
    sendPartial(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expA = '0;
    expB = '0;
    expValid = 1'b0;
    checkPair("midreset");
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_err", 32'(bus.frame_err), 32'd0);
    repeat (2) @(negedge clk);
    bus.sin_valid = 1'b0;
    rst_n = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("postreset_errcnt", 32'(errPulses), 32'(expErr));
    checkOutput("postreset_busy", 32'(bus.busy), 32'd0);

`ifdef CMP_LOADER_PARITY_EN
    $display("[TB] parity");
    bus.op_ready = 1'b0;
    applyStimulus(4'h9, 4'h3, 0, 1'b1, 1'b0);
    finishFrame("par_bad", 4'h9, 4'h3, 1'b0);
    applyStimulus(4'h9, 4'h3, 0, 1'b0, 1'b0);
    finishFrame("par_good", 4'h9, 4'h3, 1'b1);
    applyStimulus(4'h1, 4'h1, 0, 1'b1, 1'b0);
    finishFrame("par_overrun", 4'h1, 4'h1, 1'b0);
`endif

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(2));
      ra = W'($urandom_range(2**W - 1));
      rb = W'($urandom_range(2**W - 1));
`ifdef CMP_LOADER_PARITY_EN
      bad = ($urandom_range(3) == 0);
`else
      bad = 1'b0;
`endif
      bus.op_ready = (mode != 1);
      if (mode == 2) begin
        sendPartial(int'($urandom_range(FLEN - 1, 1)));
        expErr++;
      end
      applyStimulus(ra, rb, 30, bad, 1'b0);
      finishFrame("random", ra, rb, !bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
